// File: rtl/shift_frame_sequencer.sv
// shift_frame_sequencer: owns one Shift_Register frame lifecycle (tick, parallel load, shift-out capture, handshakes)
module shift_frame_sequencer #(
  parameter int nrOfBits   = 1,
  parameter int nrOfStages = 8,
  parameter int tickDiv    = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic [nrOfBits*nrOfStages-1:0] inData,
  input  logic [nrOfBits-1:0]            fillBits,
  output logic [nrOfBits*nrOfStages-1:0] srD,
  output logic                           srParLoad,
  output logic                           srShiftEnable,
  output logic                           srTick,
  output logic [nrOfBits-1:0]            srShiftIn,
  input  logic [nrOfBits-1:0]            srShiftOut,
  output logic                           outValid,
  input  logic                           outReady,
  output logic [nrOfBits*nrOfStages-1:0] outData,
  output logic                           busy
);
  localparam int W  = nrOfBits * nrOfStages;
  localparam int TW = tickDiv > 1 ? $clog2(tickDiv) : 1;
  localparam int CW = $clog2(nrOfStages + 1);
  localparam logic [TW-1:0] TC_LAST  = TW'(tickDiv - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(nrOfStages - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        r_state;
  logic [TW-1:0] r_tc;
  logic [TW-1:0] w_tc_nxt;
  logic          r_tick;
  logic          r_full;
  logic          r_par_load;
  logic          r_shift_en;
  logic          r_out_valid;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_buf;
  logic [W-1:0]  r_cap;
  logic [W-1:0]  w_shift;
  logic          w_load_go;

  // tick is registered against the next count so it reads 0 while in reset
  assign w_tc_nxt = r_tc == TC_LAST ? '0 : r_tc + 1'b1;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_tc   <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tc   <= w_tc_nxt;
      r_tick <= w_tc_nxt == TC_LAST;
    end

  assign w_load_go = r_state == LOAD && r_tick;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_full <= 1'b0;
      r_buf  <= '0;
    end else if (inValid && !r_full) begin
      r_full <= 1'b1;
      r_buf  <= inData;
    end else if (w_load_go)
      r_full <= 1'b0;

  // whole-word shift, then each lane's bit 0 is overwritten with its own shiftOut
  always_comb begin
    w_shift = r_cap << 1;
    for (int n = 0; n < nrOfBits; n++) w_shift[n*nrOfStages] = srShiftOut[n];
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state     <= IDLE;
      r_par_load  <= 1'b0;
      r_shift_en  <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_cap       <= '0;
    end else
      case (r_state)
        IDLE:
          if (r_full) begin
            r_state    <= LOAD;
            r_par_load <= 1'b1;
          end
        LOAD:
          if (r_tick) begin
            r_state    <= SHIFT;
            r_par_load <= 1'b0;
            r_shift_en <= 1'b1;
            r_cnt      <= '0;
          end
        SHIFT:
          if (r_tick) begin
            r_cap <= w_shift;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state     <= DONE;
              r_shift_en  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        default:
          if (outReady) begin
            r_state     <= r_full ? LOAD : IDLE;
            r_par_load  <= r_full;
            r_out_valid <= 1'b0;
          end
      endcase

  assign inReady       = !r_full;
  assign srTick        = r_tick;
  assign srParLoad     = r_par_load;
  assign srShiftEnable = r_shift_en;
  assign srD           = r_par_load ? r_buf : '0;
  assign srShiftIn     = r_shift_en ? fillBits : '0;
  assign outValid      = r_out_valid;
  assign outData       = r_cap;
  assign busy          = r_state != IDLE;
endmodule

// File: tb/tb_shift_frame_sequencer.sv
// tb_shift_frame_sequencer: three sequencer configs, each driving a behavioural shift register model
module tb_shift_frame_sequencer;
  localparam int NB[3] = '{1, 2, 2};
  localparam int NS[3] = '{8, 4, 4};
  localparam int TD[3] = '{1, 1, 3};

  typedef struct {
    int         inst;
    logic [7:0] din;
    logic [1:0] fl;
    logic [7:0] dout;
    logic [7:0] reg_exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid[3], in_ready[3], pl[3], se[3], tick[3], out_valid[3], out_ready[3], busy[3];
  logic [7:0] in_data[3], sr_d[3], out_data[3], sr_q[3];
  logic [1:0] fill[3], sin[3], sout[3];
  logic       sin_a;
  logic [7:0] sb[3][$];
  int         n_chk = 0, n_fail = 0, cyc = 0, nacc = 0;
  vec_t       tbl[7];
  logic [7:0] b2b[3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] bp[3]  = '{8'h5A, 8'hC3, 8'h7E};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_frame_sequencer #(.nrOfBits(1), .nrOfStages(8), .tickDiv(1)) u_a (
    .clock(clk), .reset(rst_n), .inValid(in_valid[0]), .inReady(in_ready[0]), .inData(in_data[0]),
    .fillBits(fill[0][0]), .srD(sr_d[0]), .srParLoad(pl[0]), .srShiftEnable(se[0]), .srTick(tick[0]),
    .srShiftIn(sin_a), .srShiftOut(sout[0][0]), .outValid(out_valid[0]), .outReady(out_ready[0]),
    .outData(out_data[0]), .busy(busy[0]));
  shift_frame_sequencer #(.nrOfBits(2), .nrOfStages(4), .tickDiv(1)) u_b (
    .clock(clk), .reset(rst_n), .inValid(in_valid[1]), .inReady(in_ready[1]), .inData(in_data[1]),
    .fillBits(fill[1]), .srD(sr_d[1]), .srParLoad(pl[1]), .srShiftEnable(se[1]), .srTick(tick[1]),
    .srShiftIn(sin[1]), .srShiftOut(sout[1]), .outValid(out_valid[1]), .outReady(out_ready[1]),
    .outData(out_data[1]), .busy(busy[1]));
  shift_frame_sequencer #(.nrOfBits(2), .nrOfStages(4), .tickDiv(3)) u_c (
    .clock(clk), .reset(rst_n), .inValid(in_valid[2]), .inReady(in_ready[2]), .inData(in_data[2]),
    .fillBits(fill[2]), .srD(sr_d[2]), .srParLoad(pl[2]), .srShiftEnable(se[2]), .srTick(tick[2]),
    .srShiftIn(sin[2]), .srShiftOut(sout[2]), .outValid(out_valid[2]), .outReady(out_ready[2]),
    .outData(out_data[2]), .busy(busy[2]));

  assign sin[0] = {1'b0, sin_a};

  function automatic logic [7:0] sr_step(logic [7:0] q, logic [1:0] s, int nb, int ns);
    int m = (1 << ns) - 1;
    int r = 0;
    int lane;
    for (int n = 0; n < nb; n++) begin
      lane = (int'(q) >> (n * ns)) & m;
      lane = ((lane << 1) | int'(s[n])) & m;
      r = r | (lane << (n * ns));
    end
    return r[7:0];
  endfunction

  function automatic logic [1:0] sr_out(logic [7:0] q, int nb, int ns);
    logic [1:0] o = '0;
    for (int n = 0; n < nb; n++) o[n] = q[(n + 1) * ns - 1];
    return o;
  endfunction

  // Shift_Register stand-in (negateClock=0): parLoad wins over shiftEnable, both tick-qualified
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (tick[i] && pl[i]) sr_q[i] <= sr_d[i];
      else if (tick[i] && se[i]) sr_q[i] <= sr_step(sr_q[i], sin[i], NB[i], NS[i]);

  always_comb
    for (int i = 0; i < 3; i++) sout[i] = sr_out(sr_q[i], NB[i], NS[i]);

  function automatic logic [23:0] outs(int i);
    return {in_ready[i], out_valid[i], busy[i], pl[i], se[i], tick[i], sin[i], sr_d[i], out_data[i]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic run_frame(input int i, input logic [7:0] d, input logic [1:0] f, output logic [7:0] od,
                           output logic [7:0] rq, output int lat, output int pl_n, output int se_n);
    int w = 0;
    in_data[i] = d; fill[i] = f; in_valid[i] = 1'b1; out_ready[i] = 1'b0;
    while (!in_ready[i] && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    lat = 0; pl_n = 0; se_n = 0;
    while (!out_valid[i] && lat < 300) begin
      pl_n += int'(pl[i]);
      se_n += int'(se[i]);
      @(posedge clk); #1;
      lat++;
    end
    od = out_data[i];
    rq = sr_q[i];
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
  endtask

  task automatic feed(input int i, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, output int acc[3]);
    logic [7:0] v[3];
    v = '{d0, d1, d2};
    for (int k = 0; k < 3; k++) begin
      int w = 0;
      in_data[i] = v[k]; in_valid[i] = 1'b1;
      while (!in_ready[i] && w < 100) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      acc[k] = cyc;
      nacc++;
    end
    in_valid[i] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] od, rq, hv;
    int lat, pn, sn, i, bad, cnt_a, cnt_c, last_c, gap_bad, nouts, w;
    int acc[3];
    int ot[$];
    logic [7:0] oq[$];
    logic held[3];
    logic [7:0] hval[3];
    tbl[0] = '{0, 8'hA5, 2'b00, 8'hA5, 8'h00};
    tbl[1] = '{1, 8'h3C, 2'b11, 8'h3C, 8'hFF};
    tbl[2] = '{2, 8'h96, 2'b10, 8'h96, 8'hF0};
    tbl[3] = '{1, 8'h81, 2'b01, 8'h81, 8'h0F};
    tbl[4] = '{0, 8'h00, 2'b01, 8'h00, 8'hFF};
    tbl[5] = '{2, 8'hE7, 2'b00, 8'hE7, 8'h00};
    tbl[6] = '{0, 8'h3C, 2'b00, 8'h3C, 8'h00};
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; fill[k] = '0; out_ready[k] = 1'b0; held[k] = 1'b0; hval[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_outs%0d", k), 32'(outs(k)), 32'h800000);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      run_frame(tbl[k].inst, tbl[k].din, tbl[k].fl, od, rq, lat, pn, sn);
      i = tbl[k].inst;
      chk($sformatf("tbl%0d_out", k), 32'(od), 32'(tbl[k].dout));
      chk($sformatf("tbl%0d_reg", k), 32'(rq), 32'(tbl[k].reg_exp));
      chk_rng($sformatf("tbl%0d_latency", k), lat, NS[i] * TD[i] + 2, NS[i] * TD[i] + 1 + TD[i]);
      chk_rng($sformatf("tbl%0d_parload_clks", k), pn, 1, TD[i]);
      chk($sformatf("tbl%0d_shift_clks", k), 32'(sn), 32'(NS[i] * TD[i]));
    end

    cnt_a = 0; cnt_c = 0; last_c = -1; gap_bad = 0;
    for (int c = 0; c < 30; c++) begin
      cnt_a += int'(tick[0]);
      if (tick[2]) begin
        if (last_c >= 0 && c - last_c != 3) gap_bad++;
        last_c = c;
        cnt_c++;
      end
      @(posedge clk); #1;
    end
    chk("tick_div1_count", 32'(cnt_a), 32'd30);
    chk("tick_div3_count", 32'(cnt_c), 32'd10);
    chk("tick_div3_gaps", 32'(gap_bad), 32'd0);

    out_ready[0] = 1'b1;
    ot.delete(); oq.delete(); nacc = 0;
    fork
      feed(0, b2b[0], b2b[1], b2b[2], acc);
      for (int c = 0; c < 50; c++) begin
        @(posedge clk); #1;
        if (out_valid[0]) begin oq.push_back(out_data[0]); ot.push_back(cyc); end
      end
    join
    chk("b2b_count", 32'(oq.size()), 32'd3);
    for (int k = 0; k < oq.size() && k < 3; k++) chk($sformatf("b2b_data%0d", k), 32'(oq[k]), 32'(b2b[k]));
    if (ot.size() == 3) begin
      chk("b2b_first_latency", 32'(ot[0] - acc[0]), 32'd10);
      chk("b2b_spacing1", 32'(ot[1] - ot[0]), 32'd10);
      chk("b2b_spacing2", 32'(ot[2] - ot[1]), 32'd10);
      chk_rng("b2b_second_accept", acc[1], acc[0] + 3, acc[0] + 10);
    end

    out_ready[0] = 1'b0;
    oq.delete(); nacc = 0;
    fork
      feed(0, bp[0], bp[1], bp[2], acc);
      begin
        w = 0;
        while (!out_valid[0] && w < 100) begin @(posedge clk); #1; w++; end
        chk("bp_valid", 32'(out_valid[0]), 32'd1);
        hv = out_data[0];
        bad = 0;
        repeat (20) begin
          @(posedge clk); #1;
          if (!out_valid[0] || out_data[0] !== hv) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_held_data", 32'(hv), 32'(bp[0]));
        chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
        chk("bp_accepted", 32'(nacc), 32'd2);
        out_ready[0] = 1'b1;
        for (int c = 0; c < 50; c++) begin
          if (out_valid[0]) oq.push_back(out_data[0]);
          @(posedge clk); #1;
        end
      end
    join
    chk("bp_drain_count", 32'(oq.size()), 32'd3);
    for (int k = 0; k < oq.size() && k < 3; k++) chk($sformatf("bp_drain%0d", k), 32'(oq[k]), 32'(bp[k]));
    out_ready[0] = 1'b0;

    in_data[1] = 8'h96; fill[1] = 2'b00; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    w = 0;
    while (!se[1] && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    chk("midshift_busy", 32'(busy[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midshift_reset_outs", 32'(outs(1)), 32'h800000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(in_ready[1]), 32'd1);
    run_frame(1, 8'h4B, 2'b10, od, rq, lat, pn, sn);
    chk("post_reset_out", 32'(od), 32'h4B);
    chk("post_reset_reg", 32'(rq), 32'hF0);

    nouts = 0;
    for (int c = 0; c < 1700; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (c < 1400) begin
          in_valid[k] = 1'($urandom_range(0, 1));
          in_data[k] = 8'($urandom);
          fill[k] = 2'($urandom);
          out_ready[k] = $urandom_range(0, 3) != 0;
        end else begin
          in_valid[k] = 1'b0;
          out_ready[k] = 1'b1;
        end
      #1;
      for (int k = 0; k < 3; k++) begin
        if (held[k]) chk($sformatf("rnd_hold%0d", k), 32'({out_valid[k], out_data[k]}), 32'({1'b1, hval[k]}));
        if (in_valid[k] && in_ready[k]) sb[k].push_back(in_data[k]);
        if (out_valid[k] && out_ready[k]) begin
          nouts++;
          if (sb[k].size() == 0) chk($sformatf("rnd_unexpected%0d", k), 32'(out_data[k]), 32'h100);
          else chk($sformatf("rnd_data%0d", k), 32'(out_data[k]), 32'(sb[k].pop_front()));
        end
        held[k] = out_valid[k] && !out_ready[k];
        hval[k] = out_data[k];
      end
    end
    for (int k = 0; k < 3; k++) chk($sformatf("rnd_leftover%0d", k), 32'(sb[k].size()), 32'd0);
    chk_rng("rnd_frame_count", nouts, 30, 100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
